keccak_arbiter: RTL and testbench

- Two-requester front-end that shares one keccak core, in the 32-bit word / is_last / byte_num input format the core already uses.
- Grants the core for one whole message at a time, round-robin.
- Issues the one-cycle core reset the core needs between messages, then forwards words under buffer_full backpressure.
- Captures the 512-bit digest on out_ready and returns it tagged with the requester id; a watchdog recovers a core that never finishes.

---
 rtl/keccak_arbiter.sv | 141 ++++++++++++++
 tb/tb_keccak_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arbiter.sv
// Two-requester front-end for one keccak core: whole-message round-robin
// grants, a one-cycle core reset before each message, word forwarding under
// core backpressure, digest capture and a watchdog for a core that hangs.
module keccak_arbiter #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic [31:0]  req0_data,
  input  logic         req0_last,
  input  logic [1:0]   req0_byte_num,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [31:0]  req1_data,
  input  logic         req1_last,
  input  logic [1:0]   req1_byte_num,
  output logic         req1_ready,
  output logic         core_reset,
  output logic [31:0]  core_in,
  output logic         core_in_ready,
  output logic         core_is_last,
  output logic [1:0]   core_byte_num,
  input  logic         core_buffer_full,
  input  logic [511:0] core_out,
  input  logic         core_out_ready,
  output logic [511:0] digest,
  output logic         digest_valid,
  output logic         digest_id,
  output logic         timeout_err,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, CLR, FEED, WAIT, DONE} state_t;

  // Watchdog fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  logic               rr, g, g_nxt, pick, hs, tmo;
  logic [CNT_W-1:0]   wdog;
  logic [1:0]         v, l, rdy;
  logic [1:0][31:0]   d;
  logic [1:0][1:0]    bn;

  // Requesters packed by id so the grant mux is a single index.
  assign v  = {req1_valid, req0_valid};
  assign l  = {req1_last, req0_last};
  assign d  = {req1_data, req0_data};
  assign bn = {req1_byte_num, req0_byte_num};
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign busy = (state != IDLE);

  // A lone requester wins; on a tie the one not served last wins.
  assign pick = (v == 2'b11) ? ~rr : v[1];

  // A digest arriving on the expiry cycle takes priority over the abort.
  assign tmo = (state == WAIT) && !core_out_ready && (wdog == WD_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, grant choice and core-side muxing
  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    core_in       = '0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = '0;
    rdy           = '0;
    hs            = 1'b0;
    unique case (state)
      IDLE: if (|v) begin
        g_nxt     = pick;
        state_nxt = CLR;
      end
      CLR:  state_nxt = FEED;
      FEED: begin
        core_in       = d[g];
        core_is_last  = l[g];
        core_byte_num = bn[g];
        core_in_ready = v[g];
        rdy[g]        = !core_buffer_full;
        hs            = v[g] && !core_buffer_full;
        if (hs && l[g]) state_nxt = WAIT;
      end
      WAIT: begin
        if (core_out_ready) state_nxt = DONE;
        else if (tmo)       state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant owner and round-robin pointer (pointer moves when a message retires)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g  <= 1'b0;
      rr <= 1'b1;
    end else begin
      g <= g_nxt;
      if (state == DONE || tmo) rr <= g;
    end
  end

  // Watchdog: cleared on the last word, counts only while waiting on the core
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                wdog <= '0;
    else if (hs && l[g])         wdog <= '0;
    else if (state == WAIT)      wdog <= wdog + CNT_W'(1);
  end

  // Core reset: held through reset, one cycle in CLR, one cycle after an abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) core_reset <= 1'b1;
    else          core_reset <= (state_nxt == CLR) || tmo;
  end

  // Digest capture and the one-cycle status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digest       <= '0;
      digest_id    <= 1'b0;
      digest_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      digest_valid <= (state == WAIT) && core_out_ready;
      timeout_err  <= tmo;
      if (state == WAIT && core_out_ready) begin
        digest    <= core_out;
        digest_id <= g;
      end
    end
  end
endmodule

// File: tb/tb_keccak_arbiter.sv
// Bench for keccak_arbiter: a stub core that folds received words into a
// fake 512-bit digest, requester drivers, a FEED-phase vector table, hand
// sequences for reset/backpressure/padding/timeout, and a randomized contest
// checked against a round-robin ordering model.
module tb_keccak_arbiter;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   rv = '0;
  logic [1:0]   rl = '0;
  logic [31:0]  rd [2];
  logic [1:0]   rb [2];
  logic         req0_ready, req1_ready;
  logic         core_reset, core_in_ready, core_is_last;
  logic [31:0]  core_in;
  logic [1:0]   core_byte_num;
  logic         core_buffer_full;
  logic [511:0] core_out = '0;
  logic         core_out_ready = 1'b0;
  logic [511:0] digest;
  logic         digest_valid, digest_id, timeout_err, busy;

  logic bf_mode = 1'b0, bf_man = 1'b0, bf_rnd = 1'b0;
  assign core_buffer_full = bf_mode ? bf_rnd : bf_man;

  keccak_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(rv[0]), .req0_data(rd[0]), .req0_last(rl[0]), .req0_byte_num(rb[0]), .req0_ready(req0_ready),
    .req1_valid(rv[1]), .req1_data(rd[1]), .req1_last(rl[1]), .req1_byte_num(rb[1]), .req1_ready(req1_ready),
    .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out), .core_out_ready(core_out_ready),
    .digest(digest), .digest_valid(digest_valid), .digest_id(digest_id),
    .timeout_err(timeout_err), .busy(busy));

  always #5 clk = ~clk;

  int chk = 0, err = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fake digest: fold each word, in order, into a rotating 512-bit state.
  function automatic logic [511:0] hashq(input logic [31:0] q [$]);
    logic [511:0] h = '0;
    foreach (q[i]) h = {h[479:0], h[511:480] ^ q[i] ^ (32'h9e3779b9 * (i + 1))};
    return h;
  endfunction

  // Message store, per requester
  logic [31:0] mw [2][8][8];
  int          mlen [2][8];
  logic [1:0]  mbn [2][8];

  function automatic logic [511:0] ref_dig(input int id, input int m);
    logic [31:0] q [$];
    for (int w = 0; w < mlen[id][m]; w++) q.push_back(mw[id][m][w]);
    return hashq(q);
  endfunction

  // Stub core: captures handshaken words, answers two cycles after the last one
  typedef struct packed {logic [31:0] w; logic l; logic [1:0] b;} hs_t;
  hs_t         all_hs [$];
  logic [31:0] cw_q [$];
  int          lat = -1;
  logic        stub_hang = 1'b0;
  always @(posedge clk) begin
    if (core_reset) begin
      cw_q.delete();
      lat = -1;
      core_out_ready <= 1'b0;
    end else if (core_in_ready && !core_buffer_full) begin
      cw_q.push_back(core_in);
      all_hs.push_back({core_in, core_is_last, core_byte_num});
      if (core_is_last) lat = 2;
    end else if (lat > 0) begin
      lat = lat - 1;
    end else if (lat == 0 && !stub_hang) begin
      core_out <= hashq(cw_q);
      core_out_ready <= 1'b1;
      lat = -1;
    end
  end

  // Random backpressure, changed just after each edge
  always @(posedge clk) begin
    #1 bf_rnd = ($urandom_range(3) == 0);
  end

  // Monitor: digests, pulses and event cycle stamps
  int cyc = 0, dv_cnt = 0, to_cnt = 0, cr_rise = 0, cr_hi = 0;
  int dv_cyc = 0, ordy_cyc = 0, to_cyc = 0, hs_last_cyc = 0;
  logic to_cr = 1'b0, ordy_prev = 1'b0, cr_prev = 1'b0;
  logic         got_id [256];
  logic [511:0] got_dg [256];
  always @(negedge clk) begin
    cyc++;
    if (digest_valid) begin
      got_id[dv_cnt & 255] = digest_id;
      got_dg[dv_cnt & 255] = digest;
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (timeout_err) begin to_cnt++; to_cyc = cyc; to_cr = core_reset; end
    if (core_out_ready && !ordy_prev) ordy_cyc = cyc;
    ordy_prev = core_out_ready;
    if (core_reset && !cr_prev) cr_rise++;
    if (core_reset) cr_hi++;
    cr_prev = core_reset;
    if (core_in_ready && !core_buffer_full && core_is_last) hs_last_cyc = cyc;
  end

  logic [1:0] rdy;
  assign rdy = {req1_ready, req0_ready};
  int fw [2];

  // Wait for the word on requester id to be accepted (ready seen at negedge)
  task automatic wait_hs(input int id, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (rdy[id]) break;
      if (n > 600) begin
        check($sformatf("hs_timeout_req%0d", id), 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send nmsg stored messages; gap% chance of a valid bubble inside a message
  task automatic drive_req(input int id, input int nmsg, input int gap);
    int n;
    for (int m = 0; m < nmsg; m++)
      for (int w = 0; w < mlen[id][m]; w++) begin
        if (w > 0 && $urandom_range(99) < gap) begin
          rv[id] = 1'b0;
          @(posedge clk);
          #1;
        end
        rv[id] = 1'b1;
        rd[id] = mw[id][m][w];
        rl[id] = (w == mlen[id][m] - 1);
        rb[id] = rl[id] ? mbn[id][m] : 2'd0;
        wait_hs(id, n);
        if (m == 0 && w == 0) fw[id] = n;
      end
    rv[id] = 1'b0;
    rl[id] = 1'b0;
  endtask

  task automatic gen_msgs(input int id, input int n);
    for (int m = 0; m < n; m++) begin
      mlen[id][m] = $urandom_range(6, 1);
      for (int w = 0; w < mlen[id][m]; w++) mw[id][m][w] = $urandom();
      mbn[id][m] = 2'($urandom_range(3));
    end
  endtask

  task automatic wait_dv(input int target);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(dv_cnt >= target && !busy) && n < 3000);
    if (n >= 3000) check("wait_digest_timeout", dv_cnt, target);
  endtask

  // Ordering model: a tie always alternates, starting with requester 0
  int rp = 0;
  task automatic check_digests(input string name, input int n0, input int n1);
    int i0 = 0, i1 = 0, id;
    bit turn = 1'b0;
    check($sformatf("%s_count", name), dv_cnt - rp, n0 + n1);
    for (int k = 0; k < n0 + n1; k++) begin
      if (i0 < n0 && (i1 >= n1 || !turn)) begin id = 0; turn = 1'b1; end
      else begin id = 1; turn = 1'b0; end
      check($sformatf("%s_id%0d", name, k), got_id[rp & 255], id);
      check($sformatf("%s_dig%0d", name, k), got_dg[rp & 255], ref_dig(id, id ? i1 : i0));
      if (id == 0) i0++; else i1++;
      rp++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // FEED-phase vectors with requester 0 granted
  typedef struct {
    logic v0, v1, full, l0; logic [1:0] b0; logic [31:0] d0, d1;
    logic [31:0] e_in; logic e_irdy, e_last; logic [1:0] e_bn; logic e_r0, e_r1;
  } vec_t;
  vec_t tab [6];

  int base, b2, b3, n;

  initial begin
    tab[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'hA000_0001, 32'hB000_0001, 32'hA000_0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tab[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 32'hA000_0002, 32'hB000_0002, 32'hA000_0002, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0};
    tab[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA000_0003, 32'hB000_0003, 32'hA000_0003, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'hA000_0004, 32'hB000_0004, 32'hA000_0004, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tab[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'hA000_0005, 32'hB000_0005, 32'hA000_0005, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA000_0006, 32'hB000_0006, 32'hA000_0006, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0};
    rd[0] = '0; rd[1] = '0; rb[0] = '0; rb[1] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_pulses", {digest_valid, timeout_err, digest_id}, 0);
    check("rst_digest", digest, 0);
    check("rst_ready", rdy, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("cr_hold_until_edge", core_reset, 1);
    @(posedge clk);
    @(negedge clk);
    check("cr_release", core_reset, 0);
    check("idle_core_zero", {core_in, core_in_ready, core_is_last, core_byte_num}, 0);

    // Single message from requester 0
    @(posedge clk);
    #1;
    mw[0][0][0] = "Hell"; mw[0][0][1] = "o, w"; mw[0][0][2] = "orld"; mw[0][0][3] = "!   ";
    mlen[0][0] = 4; mbn[0][0] = 2'd1;
    base = all_hs.size(); b2 = cr_hi;
    drive_req(0, 1, 0);
    wait_dv(rp + 1);
    check("single_first_accept_latency", fw[0], 3);
    check("single_cr_cycles", cr_hi - b2, 1);
    check("single_hs_count", all_hs.size() - base, 4);
    check("single_dv_latency", dv_cyc - ordy_cyc, 1);
    check("single_last_bn", all_hs[base + 3], {mw[0][0][3], 1'b1, 2'd1});
    check_digests("single", 1, 0);

    // Simultaneous contest, then a third back-to-back grant to requester 0
    do_reset();
    gen_msgs(0, 2); gen_msgs(1, 1);
    fork
      drive_req(0, 2, 0);
      drive_req(1, 1, 0);
    join
    wait_dv(rp + 3);
    check_digests("contest", 2, 1);

    // Backpressure for 5 cycles mid-message
    mw[0][0][0] = "The "; mw[0][0][1] = "quic"; mw[0][0][2] = "k br";
    mw[0][0][3] = "own "; mw[0][0][4] = "fox "; mlen[0][0] = 5; mbn[0][0] = 2'd3;
    base = all_hs.size();
    fork
      drive_req(0, 1, 0);
      begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (all_hs.size() < base + 2 && n < 200);
        bf_man = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("bp_ready_low", req0_ready, 0);
        end
        check("bp_no_hs", all_hs.size() - base, 2);
        @(posedge clk);
        #1 bf_man = 1'b0;
      end
    join
    wait_dv(rp + 1);
    check("bp_hs_count", all_hs.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < all_hs.size())
        check($sformatf("bp_word%0d", i), all_hs[base + i].w, mw[0][0][i]);
    check_digests("bp", 1, 0);

    // Padding-only final word from requester 1
    gen_msgs(1, 1);
    mlen[1][0] = 5; mw[1][0][4] = '0; mbn[1][0] = 2'd0;
    base = all_hs.size();
    drive_req(1, 1, 0);
    wait_dv(rp + 1);
    check("pad_hs_count", all_hs.size() - base, 5);
    if (all_hs.size() >= base + 5) begin
      check("pad_word4", all_hs[base + 3].l, 0);
      check("pad_last", all_hs[base + 4], {32'h0, 1'b1, 2'd0});
    end
    check_digests("pad", 0, 1);

    // Watchdog abort with a core that never answers
    stub_hang = 1'b1;
    gen_msgs(0, 1); gen_msgs(1, 1);
    b2 = to_cnt; b3 = cr_rise;
    drive_req(0, 1, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (to_cnt == b2 && n < 200);
    @(posedge clk);
    #1;
    check("to_pulses", to_cnt - b2, 1);
    check("to_delay", to_cyc - hs_last_cyc, 17);
    check("to_core_reset", to_cr, 1);
    check("to_cr_rises", cr_rise - b3, 2);
    check("to_no_digest", dv_cnt - rp, 0);
    check("to_idle", busy, 0);
    stub_hang = 1'b0;
    drive_req(1, 1, 0);
    wait_dv(rp + 1);
    check_digests("to_next", 0, 1);

    // FEED vector table, requester 0 granted, requester 1 contending
    do_reset();
    bf_man = 1'b1; rv[0] = 1'b1; rd[0] = 32'hA000_0000; rl[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    foreach (tab[i]) begin
      rv = {tab[i].v1, tab[i].v0}; bf_man = tab[i].full;
      rd[0] = tab[i].d0; rd[1] = tab[i].d1; rl[0] = tab[i].l0; rb[0] = tab[i].b0;
      @(negedge clk);
      check($sformatf("feed_vec%0d", i),
            {core_in, core_in_ready, core_is_last, core_byte_num, req0_ready, req1_ready},
            {tab[i].e_in, tab[i].e_irdy, tab[i].e_last, tab[i].e_bn, tab[i].e_r0, tab[i].e_r1});
      @(posedge clk);
      #1;
    end
    rv = 2'b01; bf_man = 1'b0; rd[0] = 32'hA000_0007; rl[0] = 1'b1; rb[0] = 2'd1;
    @(posedge clk);
    #1 rv = '0; rl[0] = 1'b0;
    mw[0][0][0] = 32'hA000_0002; mw[0][0][1] = 32'hA000_0005; mw[0][0][2] = 32'hA000_0007; mlen[0][0] = 3;
    wait_dv(rp + 1);
    check_digests("feed_tab", 1, 0);

    // Async reset in the middle of a message
    do_reset();
    rv = 2'b11; rd[0] = 32'h1111_0000; rd[1] = 32'h2222_0000; rl = '0;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_core_reset", core_reset, 1);
    check("arst_ready", rdy, 0);
    rv = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    gen_msgs(0, 1);
    drive_req(0, 1, 0);
    wait_dv(rp + 1);
    check_digests("arst_after", 1, 0);

    // Randomized contest with bubbles and random backpressure
    do_reset();
    bf_mode = 1'b1;
    gen_msgs(0, 4); gen_msgs(1, 3);
    fork
      drive_req(0, 4, 30);
      drive_req(1, 3, 30);
    join
    wait_dv(rp + 7);
    bf_mode = 1'b0;
    check_digests("rand", 4, 3);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", err);
    $fatal(1);
  end
endmodule
